// File: rtl/hh_packet_source.sv
// rtl/hh_packet_source.sv - Backscatter packet serializer for the HitchHike tag datapath
//
// Builds one frame per start: PREAMBLE_REPS copies of the preamble byte, the
// loaded payload (top byte first, each byte repeated BYTE_REPS times, MSB
// first), then TAIL_BITS zeros. Each bit is held for BIT_PERIOD clocks.
//
// Ports:
//   clock        clock, all logic on posedge
//   reset        synchronous active-high reset (clears payload too)
//   enable       0 forces IDLE without a done pulse; payload retained
//   continuous   1 restarts the frame from DONE while enable=1
//   start        frame request, honoured only in IDLE
//   load_valid   payload load request, accepted when load_ready=1
//   load_data    payload, byte [top] sent first
//   load_ready   1 iff in IDLE
//   output_data  registered serial bit to the modulator
//   bit_strobe   one-clock pulse when a new bit is registered
//   busy         1 while a frame is being sent
//   done         one-clock pulse on frame completion
module hh_packet_source #(
    parameter int         PAYLOAD_BYTES = 4,
    parameter int         BIT_PERIOD    = 50,
    parameter logic [7:0] PREAMBLE      = 8'b10010010,
    parameter int         PREAMBLE_REPS = 6,
    parameter int         BYTE_REPS     = 3,
    parameter int         TAIL_BITS     = 24
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       continuous,
    input  logic                       start,
    input  logic                       load_valid,
    input  logic [8*PAYLOAD_BYTES-1:0] load_data,
    output logic                       load_ready,
    output logic                       output_data,
    output logic                       bit_strobe,
    output logic                       busy,
    output logic                       done
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_PAY  = 3'd2;
    localparam logic [2:0] ST_TAIL = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam int BC_W = $clog2(BIT_PERIOD);
    localparam int MAXR = (PREAMBLE_REPS > BYTE_REPS) ? PREAMBLE_REPS : BYTE_REPS;
    localparam int RW   = (MAXR > 1) ? $clog2(MAXR) : 1;
    localparam int BW   = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam int TW   = (TAIL_BITS > 1) ? $clog2(TAIL_BITS) : 1;
    localparam int PIW  = $clog2(8 * PAYLOAD_BYTES);

    localparam logic [7:0] PRE_B = PREAMBLE;

    logic [2:0]                 state;
    logic [BC_W-1:0]            bit_cnt;
    logic [2:0]                 bit_pos;
    logic [RW-1:0]              rep;
    logic [BW-1:0]              byte_idx;
    logic [TW-1:0]              tail_cnt;
    logic [8*PAYLOAD_BYTES-1:0] payload;

    logic [2:0]      n_state;
    logic [2:0]      n_bit;
    logic [RW-1:0]   n_rep;
    logic [BW-1:0]   n_byte;
    logic [TW-1:0]   n_tail;
    logic            n_data;
    logic [PIW-1:0]  pidx;
    logic            launch;
    logic            wrap;

    assign load_ready = (state == ST_IDLE);
    assign wrap       = (bit_cnt == BC_W'(BIT_PERIOD - 1));
    // A frame starts from IDLE on start, or straight out of DONE in continuous mode.
    assign launch     = enable && (((state == ST_IDLE) && start) ||
                                   ((state == ST_DONE) && continuous));

    // Frame position after the current bit period ends, and the bit it selects.
    always_comb begin
        n_state = state;
        n_bit   = bit_pos;
        n_rep   = rep;
        n_byte  = byte_idx;
        n_tail  = tail_cnt;
        n_data  = 1'b0;
        pidx    = '0;
        case (state)
            ST_PRE: begin
                if (bit_pos != 3'd7) begin
                    n_bit = bit_pos + 1'b1;
                end else begin
                    n_bit = 3'd0;
                    if (rep != RW'(PREAMBLE_REPS - 1)) begin
                        n_rep = rep + 1'b1;
                    end else begin
                        n_rep   = '0;
                        n_byte  = '0;
                        n_state = ST_PAY;
                    end
                end
            end
            ST_PAY: begin
                if (bit_pos != 3'd7) begin
                    n_bit = bit_pos + 1'b1;
                end else begin
                    n_bit = 3'd0;
                    if (rep != RW'(BYTE_REPS - 1)) begin
                        n_rep = rep + 1'b1;
                    end else begin
                        n_rep = '0;
                        if (byte_idx != BW'(PAYLOAD_BYTES - 1)) begin
                            n_byte = byte_idx + 1'b1;
                        end else begin
                            n_byte  = '0;
                            n_state = (TAIL_BITS > 0) ? ST_TAIL : ST_DONE;
                        end
                    end
                end
            end
            ST_TAIL: begin
                if (tail_cnt != TW'(TAIL_BITS - 1)) begin
                    n_tail = tail_cnt + 1'b1;
                end else begin
                    n_tail  = '0;
                    n_state = ST_DONE;
                end
            end
            default: ;
        endcase
        pidx = PIW'(8 * (PAYLOAD_BYTES - 1 - int'(n_byte)) + 7 - int'(n_bit));
        case (n_state)
            ST_PRE:  n_data = PRE_B[3'd7 - n_bit];
            ST_PAY:  n_data = payload[pidx];
            default: n_data = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            bit_pos     <= '0;
            rep         <= '0;
            byte_idx    <= '0;
            tail_cnt    <= '0;
            payload     <= '0;
            output_data <= 1'b0;
            bit_strobe  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            // Loading is independent of enable; a same-edge start sees the new payload.
            if (load_valid && load_ready) begin
                payload <= load_data;
            end
            if (!enable) begin
                state       <= ST_IDLE;
                bit_cnt     <= '0;
                bit_pos     <= '0;
                rep         <= '0;
                byte_idx    <= '0;
                tail_cnt    <= '0;
                output_data <= 1'b0;
                bit_strobe  <= 1'b0;
                busy        <= 1'b0;
                done        <= 1'b0;
            end else if (launch) begin
                state       <= ST_PRE;
                bit_cnt     <= '0;
                bit_pos     <= '0;
                rep         <= '0;
                byte_idx    <= '0;
                tail_cnt    <= '0;
                output_data <= PRE_B[7];
                bit_strobe  <= 1'b1;
                busy        <= 1'b1;
                done        <= 1'b0;
            end else begin
                case (state)
                    ST_PRE, ST_PAY, ST_TAIL: begin
                        if (wrap) begin
                            bit_cnt  <= '0;
                            state    <= n_state;
                            bit_pos  <= n_bit;
                            rep      <= n_rep;
                            byte_idx <= n_byte;
                            tail_cnt <= n_tail;
                            if (n_state == ST_DONE) begin
                                output_data <= 1'b0;
                                bit_strobe  <= 1'b0;
                                busy        <= 1'b0;
                                done        <= 1'b1;
                            end else begin
                                output_data <= n_data;
                                bit_strobe  <= 1'b1;
                            end
                        end else begin
                            bit_cnt    <= bit_cnt + 1'b1;
                            bit_strobe <= 1'b0;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        done  <= 1'b0;
                    end
                    default: begin
                        bit_strobe <= 1'b0;
                        done       <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hh_packet_source.sv
// tb/tb_hh_packet_source.sv - Self-checking bench for hh_packet_source
module tb_hh_packet_source;

    logic        clk = 1'b0;
    logic        reset, enable, continuous, start, load_valid;
    logic [31:0] load_data;
    logic        load_ready, output_data, bit_strobe, busy, done;

    logic        enable2, continuous2, start2, load_valid2;
    logic [31:0] load_data2;
    logic        load_ready2, output_data2, bit_strobe2, busy2, done2;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_q[$];
    logic bits_q[$];
    int   holds_q[$];

    always #5 clk = ~clk;

    hh_packet_source u_dut (
        .clock(clk), .reset(reset), .enable(enable), .continuous(continuous),
        .start(start), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .output_data(output_data), .bit_strobe(bit_strobe),
        .busy(busy), .done(done)
    );

    hh_packet_source #(.BIT_PERIOD(2), .TAIL_BITS(0)) u_dut2 (
        .clock(clk), .reset(reset), .enable(enable2), .continuous(continuous2),
        .start(start2), .load_valid(load_valid2), .load_data(load_data2),
        .load_ready(load_ready2), .output_data(output_data2), .bit_strobe(bit_strobe2),
        .busy(busy2), .done(done2)
    );

    // Expected bit sequence of one frame, pushed when a frame is requested.
    task automatic push_frame(input logic [31:0] pl, input int tail);
        logic [7:0] pb;
        pb = 8'b10010010;
        for (int r = 0; r < 6; r++)
            for (int b = 7; b >= 0; b--) exp_q.push_back(pb[b]);
        for (int by = 3; by >= 0; by--)
            for (int r = 0; r < 3; r++)
                for (int b = 7; b >= 0; b--) exp_q.push_back(pl[8*by+b]);
        for (int t = 0; t < tail; t++) exp_q.push_back(1'b0);
    endtask

    // Observes u_dut from the cycle after a start until done; optionally pokes
    // load/start once mid-frame. Records bits, hold lengths and status anomalies.
    task automatic collect(input int budget, input int poke_cyc,
                           output int done_cyc, output int bad_status);
        int hold;
        hold = 0;
        done_cyc = -1;
        bad_status = 0;
        bits_q.delete();
        holds_q.delete();
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            start = 1'b0;
            load_valid = 1'b0;
            if (done === 1'b1) begin
                done_cyc = c;
                if (hold > 0) holds_q.push_back(hold);
                if (output_data !== 1'b0 || busy !== 1'b0) bad_status++;
                break;
            end
            if (bit_strobe === 1'b1) begin
                if (hold > 0) holds_q.push_back(hold);
                bits_q.push_back(output_data);
                hold = 1;
            end else begin
                hold++;
                if (bits_q.size() > 0 && output_data !== bits_q[$]) bad_status++;
            end
            if (busy !== 1'b1 || load_ready !== 1'b0) bad_status++;
            if (c == poke_cyc) begin
                load_valid = 1'b1;
                start = 1'b1;
                load_data = 32'h1234_5678;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; enable = 1'b1; continuous = 1'b0; start = 1'b0;
        load_valid = 1'b0; load_data = '0;
        enable2 = 1'b1; continuous2 = 1'b0; start2 = 1'b0; load_valid2 = 1'b0; load_data2 = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (output_data !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            load_ready !== 1'b1 || bit_strobe !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state got out=%b busy=%b done=%b ready=%b strobe=%b want 0 0 0 1 0",
                     output_data, busy, done, load_ready, bit_strobe);
        end
        reset = 1'b0;
    endtask

    task automatic test_frame;
        int dc, bad;
        @(negedge clk);
        exp_q.delete();
        push_frame(32'hAA02_55C3, 24);
        load_data = 32'hAA02_55C3; load_valid = 1'b1; start = 1'b1;
        collect(9000, -1, dc, bad);
        n_checks++;
        if (dc !== 8401) begin n_fail++; $display("FAIL frame_done_cycle got %0d want 8401", dc); end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL frame_status got %0d anomalies want 0", bad); end
        n_checks++;
        if (bits_q.size() != 168 || holds_q.size() != 168) begin
            n_fail++; $display("FAIL frame_len got %0d/%0d want 168", bits_q.size(), holds_q.size());
        end
        for (int i = 0; i < bits_q.size() && exp_q.size() > 0; i++) begin
            logic e;
            e = exp_q.pop_front();
            n_checks++;
            if (bits_q[i] !== e) begin n_fail++; $display("FAIL frame_bit[%0d] got %b want %b", i, bits_q[i], e); end
            if (i < holds_q.size()) begin
                n_checks++;
                if (holds_q[i] !== 50) begin n_fail++; $display("FAIL frame_hold[%0d] got %0d want 50", i, holds_q[i]); end
            end
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1) begin
            n_fail++; $display("FAIL frame_idle got done=%b busy=%b ready=%b want 0 0 1", done, busy, load_ready);
        end
    endtask

    task automatic test_continuous;
        int d1, d2;
        @(negedge clk);
        exp_q.delete();
        push_frame(32'h5A3C_0FF0, 0);
        push_frame(32'h5A3C_0FF0, 0);
        load_data2 = 32'h5A3C_0FF0; load_valid2 = 1'b1; start2 = 1'b1; continuous2 = 1'b1;
        d1 = -1; d2 = -1;
        bits_q.delete();
        for (int c = 1; c <= 700; c++) begin
            @(negedge clk);
            start2 = 1'b0; load_valid2 = 1'b0;
            if (d1 > 0 && c == d1 + 1) begin
                n_checks++;
                if (bit_strobe2 !== 1'b1 || output_data2 !== 1'b1 || busy2 !== 1'b1) begin
                    n_fail++; $display("FAIL cont_restart got strobe=%b out=%b busy=%b want 1 1 1",
                                       bit_strobe2, output_data2, busy2);
                end
            end
            if (done2 === 1'b1) begin
                n_checks++;
                if (output_data2 !== 1'b0 || busy2 !== 1'b0) begin
                    n_fail++; $display("FAIL cont_gap got out=%b busy=%b want 0 0", output_data2, busy2);
                end
                if (d1 < 0) d1 = c;
                else begin d2 = c; continuous2 = 1'b0; break; end
            end else if (bit_strobe2 === 1'b1) begin
                bits_q.push_back(output_data2);
            end
        end
        n_checks++;
        if (d1 !== 289 || d2 !== 578) begin n_fail++; $display("FAIL cont_done got %0d,%0d want 289,578", d1, d2); end
        n_checks++;
        if (bits_q.size() != 288) begin n_fail++; $display("FAIL cont_len got %0d want 288", bits_q.size()); end
        for (int i = 0; i < bits_q.size() && exp_q.size() > 0; i++) begin
            logic e;
            e = exp_q.pop_front();
            n_checks++;
            if (bits_q[i] !== e) begin n_fail++; $display("FAIL cont_bit[%0d] got %b want %b", i, bits_q[i], e); end
        end
        @(negedge clk);
        n_checks++;
        if (busy2 !== 1'b0 || load_ready2 !== 1'b1 || done2 !== 1'b0) begin
            n_fail++; $display("FAIL cont_stop got busy=%b ready=%b done=%b want 0 1 0", busy2, load_ready2, done2);
        end
    endtask

    task automatic test_abort;
        int dc, bad, ndone;
        @(negedge clk);
        start = 1'b1;
        // Bit 78 is bit 6 of the second payload byte (0x02), a '1'.
        for (int c = 1; c <= 3920; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        n_checks++;
        if (output_data !== 1'b1) begin n_fail++; $display("FAIL abort_pre got %b want 1", output_data); end
        enable = 1'b0;
        @(negedge clk);
        n_checks++;
        if (output_data !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || load_ready !== 1'b1) begin
            n_fail++; $display("FAIL abort_idle got out=%b busy=%b done=%b ready=%b want 0 0 0 1",
                               output_data, busy, done, load_ready);
        end
        ndone = 0;
        start = 1'b1;
        repeat (20) begin @(negedge clk); if (done === 1'b1 || busy === 1'b1) ndone++; end
        start = 1'b0;
        n_checks++;
        if (ndone !== 0) begin n_fail++; $display("FAIL abort_quiet got %0d active cycles want 0", ndone); end
        enable = 1'b1;
        @(negedge clk);
        exp_q.delete();
        push_frame(32'hAA02_55C3, 24);
        start = 1'b1;
        collect(9000, -1, dc, bad);
        n_checks++;
        if (dc !== 8401 || bad !== 0) begin n_fail++; $display("FAIL abort_refr got done=%0d bad=%0d want 8401 0", dc, bad); end
        n_checks++;
        if (bits_q.size() != 168) begin n_fail++; $display("FAIL abort_len got %0d want 168", bits_q.size()); end
        for (int i = 0; i < bits_q.size() && exp_q.size() > 0; i++) begin
            logic e;
            e = exp_q.pop_front();
            n_checks++;
            if (bits_q[i] !== e) begin n_fail++; $display("FAIL abort_bit[%0d] got %b want %b", i, bits_q[i], e); end
        end
    endtask

    task automatic test_busy_ignore;
        int dc, bad;
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            exp_q.delete();
            push_frame(32'hAA02_55C3, 24);
            start = 1'b1;
            collect(9000, (pass == 0) ? 100 : -1, dc, bad);
            n_checks++;
            if (dc !== 8401 || bad !== 0) begin
                n_fail++; $display("FAIL busy_frame%0d got done=%0d bad=%0d want 8401 0", pass, dc, bad);
            end
            n_checks++;
            if (bits_q.size() != 168) begin n_fail++; $display("FAIL busy_len%0d got %0d want 168", pass, bits_q.size()); end
            for (int i = 0; i < bits_q.size() && exp_q.size() > 0; i++) begin
                logic e;
                e = exp_q.pop_front();
                n_checks++;
                if (bits_q[i] !== e) begin n_fail++; $display("FAIL busy_bit%0d[%0d] got %b want %b", pass, i, bits_q[i], e); end
            end
        end
    endtask

    task automatic test_mid_reset;
        int dc, bad;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        n_checks++;
        if (output_data !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre got out=%b busy=%b want 1 1", output_data, busy);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (output_data !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bit_strobe !== 1'b0 || load_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid got out=%b busy=%b done=%b strobe=%b ready=%b want 0 0 0 0 1",
                               output_data, busy, done, bit_strobe, load_ready);
        end
        @(negedge clk);
        exp_q.delete();
        push_frame(32'h0000_0000, 24);
        start = 1'b1;
        collect(9000, -1, dc, bad);
        n_checks++;
        if (dc !== 8401 || bad !== 0) begin n_fail++; $display("FAIL rst_frame got done=%0d bad=%0d want 8401 0", dc, bad); end
        n_checks++;
        if (bits_q.size() != 168) begin n_fail++; $display("FAIL rst_len got %0d want 168", bits_q.size()); end
        for (int i = 0; i < bits_q.size() && exp_q.size() > 0; i++) begin
            logic e;
            e = exp_q.pop_front();
            n_checks++;
            if (bits_q[i] !== e) begin n_fail++; $display("FAIL rst_bit[%0d] got %b want %b", i, bits_q[i], e); end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_continuous();
        test_abort();
        test_busy_ignore();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
